// File: rtl/sseg_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
// Contents: digit count, nibble/index types, active-low one-hot anode helper.
package sseg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [3:0] nibble_t;
  typedef logic [1:0] digit_idx_t;

  // Active-low one-hot anode pattern for the given digit index.
  function automatic logic [NUM_DIGITS-1:0] anode_onehot_n(input digit_idx_t idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/sseg_tick.sv
// Digit-rate divider: counts 0..CYCLES_PER_DIGIT-1 while enabled, wraps,
// and flags the terminal count.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en_i       : count enable (held low during the post-reset prime cycle)
//   step_c_o   : combinational terminal-count flag
module sseg_tick #(
  parameter int unsigned CYCLES_PER_DIGIT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic step_c_o
);

  localparam int unsigned CNT_W = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_DIGIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign step_c_o = en_i && (cnt_q == LAST);

  // Next count: wrap on terminal count, hold while disabled.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = step_c_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sseg_scan.sv
// Time-multiplexed 4-digit seven-segment scan controller.
// Optional feature: define SSEG_LZB_EN for leading-zero blanking.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   val         : 16-bit hex value, digit k = val[4k+3:4k]
//   dp_in       : per-digit decimal point request, active-high
//   blank       : forces all anodes off
//   num         : nibble to the segment decoder
//   an          : anodes, active-low
//   dp          : decimal point, active-low
//   digit_sel   : index of the digit being driven
//   frame_tick  : one-cycle pulse after each frame-boundary shadow load
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int unsigned CYCLES_PER_DIGIT = 100000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [15:0]           val,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  blank,
  output logic [3:0]            num,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic [1:0]            digit_sel,
  output logic                  frame_tick
);

  logic                  prime_q;
  logic                  step_c;
  logic                  frame_c;
  logic                  dark_c;
  logic [NUM_DIGITS-1:0] lit_c;

  digit_idx_t            idx_q, idx_d;
  logic [15:0]           val_s_q, val_s_d;
  logic [NUM_DIGITS-1:0] dp_s_q, dp_s_d;
  nibble_t               num_q, num_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  dp_q, dp_d;
  digit_idx_t            sel_q, sel_d;
  logic                  ft_q, ft_d;

  // Divider is held during the prime cycle so digit 0 gets its full slot.
  sseg_tick #(.CYCLES_PER_DIGIT(CYCLES_PER_DIGIT)) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (!prime_q),
    .step_c_o (step_c)
  );

  assign frame_c = step_c && (idx_q == digit_idx_t'(NUM_DIGITS - 1));

`ifdef SSEG_LZB_EN
  // Lit mask from the shadows: a digit is lit if it or any higher nibble is
  // nonzero, or its dp is requested; digit 0 always lit.
  always_comb begin
    lit_c = '1;
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      lit_c[k] = dp_s_q[k] || ((val_s_q >> (4 * k)) != 16'h0);
    end
  end
`else
  assign lit_c = '1;
`endif

  // The prime cycle keeps the anodes dark so the first lit digit shows real data.
  assign dark_c = blank || prime_q || !lit_c[idx_q];

  // Next-state and registered output values.
  always_comb begin
    idx_d   = idx_q;
    val_s_d = val_s_q;
    dp_s_d  = dp_s_q;
    if (step_c) idx_d = idx_q + digit_idx_t'(1);
    if (frame_c || prime_q) begin
      val_s_d = val;
      dp_s_d  = dp_in;
    end
    num_d = val_s_q[{idx_q, 2'b00} +: 4];
    an_d  = dark_c ? '1 : anode_onehot_n(idx_q);
    dp_d  = dark_c ? 1'b1 : !dp_s_q[idx_q];
    sel_d = idx_q;
    ft_d  = frame_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_q <= 1'b1;
      idx_q   <= '0;
      val_s_q <= '0;
      dp_s_q  <= '0;
      num_q   <= '0;
      an_q    <= '1;
      dp_q    <= 1'b1;
      sel_q   <= '0;
      ft_q    <= 1'b0;
    end else begin
      prime_q <= 1'b0;
      idx_q   <= idx_d;
      val_s_q <= val_s_d;
      dp_s_q  <= dp_s_d;
      num_q   <= num_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      sel_q   <= sel_d;
      ft_q    <= ft_d;
    end
  end

  assign num        = num_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign digit_sel  = sel_q;
  assign frame_tick = ft_q;

endmodule
